// File: rtl/fp2_sq_stream_ctrl.sv
// Stream wrapper for the 4-lane Fp2 squaring pipeline: packs elements into lane groups,
// tracks them through the fixed latency and replays results in order with backpressure.
module fp2_sq_stream_ctrl #(
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned W          = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  input  logic         in_last,
  output logic [W-1:0] sq_A1,
  output logic [W-1:0] sq_A2,
  output logic [W-1:0] sq_A3,
  output logic [W-1:0] sq_A4,
  output logic [W-1:0] sq_B1,
  output logic [W-1:0] sq_B2,
  output logic [W-1:0] sq_B3,
  output logic [W-1:0] sq_B4,
  input  logic [W-1:0] sq_D1_re,
  input  logic [W-1:0] sq_D2_re,
  input  logic [W-1:0] sq_D3_re,
  input  logic [W-1:0] sq_D4_re,
  input  logic [W-1:0] sq_D1_im,
  input  logic [W-1:0] sq_D2_im,
  input  logic [W-1:0] sq_D3_im,
  input  logic [W-1:0] sq_D4_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         out_last
);

  localparam int unsigned NL = 4;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [NL-1:0][W-1:0] lanes_t;
  typedef struct packed {
    lanes_t     re;
    lanes_t     im;
    logic [2:0] n;
    logic       last;
  } grp_t;
  typedef struct packed {
    logic       vld;
    logic [2:0] n;
    logic       last;
  } trk_t;

  lanes_t        slot_re_q, slot_re_d, slot_im_q, slot_im_d;
  lanes_t        sq_a_q, sq_a_d, sq_b_q, sq_b_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          closed_q, closed_d, last_q, last_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    lane_q, lane_d;
  trk_t          trk_q [LATENCY+1];
  grp_t          fifo_q [FIFO_DEPTH];

  grp_t head;
  logic accept, issue, pop, pop_last, capture, fifo_empty, last_lane;

  assign head       = fifo_q[rd_ptr_q[AW-1:0]];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign in_ready   = ~closed_q & ~rst;
  assign out_valid  = ~fifo_empty & ~rst;
  assign accept     = in_valid & in_ready;
  assign issue      = closed_q & (credit_q < CW'(FIFO_DEPTH));
  assign last_lane  = ({1'b0, lane_q} == (head.n - 3'd1));
  assign pop        = out_valid & out_ready;
  assign pop_last   = pop & last_lane;
  assign capture    = trk_q[LATENCY].vld;

  assign out_re   = out_valid ? head.re[lane_q] : '0;
  assign out_im   = out_valid ? head.im[lane_q] : '0;
  assign out_last = out_valid & head.last & last_lane;

  assign sq_A1 = sq_a_q[0];
  assign sq_A2 = sq_a_q[1];
  assign sq_A3 = sq_a_q[2];
  assign sq_A4 = sq_a_q[3];
  assign sq_B1 = sq_b_q[0];
  assign sq_B2 = sq_b_q[1];
  assign sq_B3 = sq_b_q[2];
  assign sq_B4 = sq_b_q[3];

  // Packer and lane registers; accept and issue are mutually exclusive via closed_q.
  always_comb begin
    slot_re_d = slot_re_q;
    slot_im_d = slot_im_q;
    cnt_d     = cnt_q;
    closed_d  = closed_q;
    last_d    = last_q;
    sq_a_d    = sq_a_q;
    sq_b_d    = sq_b_q;
    if (issue) begin
      for (int l = 0; l < NL; l++) begin
        sq_a_d[l] = (3'(l) < cnt_q) ? slot_re_q[l] : '0;
        sq_b_d[l] = (3'(l) < cnt_q) ? slot_im_q[l] : '0;
      end
      cnt_d    = '0;
      closed_d = 1'b0;
      last_d   = 1'b0;
    end else if (accept) begin
      slot_re_d[cnt_q[1:0]] = in_re;
      slot_im_d[cnt_q[1:0]] = in_im;
      cnt_d    = cnt_q + 3'd1;
      last_d   = in_last;
      closed_d = in_last | (cnt_q == 3'd3);
    end
  end

  // Credit covers issued-but-undrained groups, so the result buffer can never overflow.
  always_comb begin
    credit_d = credit_q;
    if (issue && !pop_last) begin
      credit_d = credit_q + CW'(1);
    end else if (!issue && pop_last) begin
      credit_d = credit_q - CW'(1);
    end
    lane_d = lane_q;
    if (pop) begin
      lane_d = pop_last ? 2'd0 : lane_q + 2'd1;
    end
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_last);
    wr_ptr_d = wr_ptr_q + (AW+1)'(capture);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_re_q <= '0;
      slot_im_q <= '0;
      cnt_q     <= '0;
      closed_q  <= 1'b0;
      last_q    <= 1'b0;
      sq_a_q    <= '0;
      sq_b_q    <= '0;
      credit_q  <= '0;
      lane_q    <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      slot_re_q <= slot_re_d;
      slot_im_q <= slot_im_d;
      cnt_q     <= cnt_d;
      closed_q  <= closed_d;
      last_q    <= last_d;
      sq_a_q    <= sq_a_d;
      sq_b_q    <= sq_b_d;
      credit_q  <= credit_d;
      lane_q    <= lane_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Stage 0 lines up with the group appearing on sq_A/sq_B; stage LATENCY with its results.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LATENCY; k++) begin
        trk_q[k] <= '0;
      end
    end else begin
      trk_q[0] <= issue ? '{vld: 1'b1, n: cnt_q, last: last_q} : '0;
      for (int k = 1; k <= LATENCY; k++) begin
        trk_q[k] <= trk_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= '{re:   {sq_D4_re, sq_D3_re, sq_D2_re, sq_D1_re},
                                    im:   {sq_D4_im, sq_D3_im, sq_D2_im, sq_D1_im},
                                    n:    trk_q[LATENCY].n,
                                    last: trk_q[LATENCY].last};
    end
  end

endmodule

// File: tb/tb_fp2_sq_stream_ctrl.sv
// Directed bench for fp2_sq_stream_ctrl with a behavioural fixed-latency squaring unit stub.
module tb_fp2_sq_stream_ctrl;

  localparam int unsigned W   = 255;
  localparam int unsigned LAT = 6;
  localparam int unsigned FD  = 2;
  localparam int unsigned NV  = 29;

  localparam logic [W-1:0] V1_RE = 255'h3807ed85e85d8b3fbd5a293a18bb42f0912b8e383d833a9a269d132d5a5167b;
  localparam logic [W-1:0] V1_IM = 255'h127ba0471a1f3d76c58bca5bc731dd6f91ae57c60ea264fecde8b73482c3495;
  localparam logic [W-1:0] V2_RE = 255'h34e0b04174d94060cacc82cd69eee90e724fe81f8a43b14ccd8904ef5a965f9;
  localparam logic [W-1:0] V2_IM = 255'h37574a8b477caf2a5f274ab5c718332ee00fefa49e0c5518b2de38c133d33ea;
  localparam logic [W-1:0] R1_RE = 255'h3c1c4f9467e51a19be97071693ad823e905a8da3ecaa181fff9bbaf6a923321;
  localparam logic [W-1:0] R1_IM = 255'h37319e18249d047e4001270f26108a057741e2280414936d5dd56bb2ac5796a;
  localparam logic [W-1:0] R2_RE = 255'h6961fa8023ef02728923172070710add14eb25535c8e17139bbb3d0ad46ef9;
  localparam logic [W-1:0] R2_IM = 255'h7a46fd2123e88c6240961494f8e20906e062222d240620f13f0044ec411a7c8;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
    logic [W-1:0] ere;
    logic [W-1:0] eim;
    logic         elast;
  } vec_t;

  logic         clk, rst, in_valid, in_ready, in_last;
  logic [W-1:0] in_re, in_im;
  logic         out_valid, out_ready, out_last;
  logic [W-1:0] out_re, out_im;
  logic [3:0][W-1:0] sq_a, sq_b;
  logic [3:0][W-1:0] pr [LAT];
  logic [3:0][W-1:0] pi [LAT];

  vec_t tbl [NV];
  vec_t exp_q [$];
  int   checks, errors, n_out, issue_cnt;

  fp2_sq_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(FD), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .sq_A1(sq_a[0]), .sq_A2(sq_a[1]), .sq_A3(sq_a[2]), .sq_A4(sq_a[3]),
    .sq_B1(sq_b[0]), .sq_B2(sq_b[1]), .sq_B3(sq_b[2]), .sq_B4(sq_b[3]),
    .sq_D1_re(pr[LAT-1][0]), .sq_D2_re(pr[LAT-1][1]), .sq_D3_re(pr[LAT-1][2]), .sq_D4_re(pr[LAT-1][3]),
    .sq_D1_im(pi[LAT-1][0]), .sq_D2_im(pi[LAT-1][1]), .sq_D3_im(pi[LAT-1][2]), .sq_D4_im(pi[LAT-1][3]),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub unit: known squares for V1/V2, a cheap distinct mapping for everything else.
  function automatic logic [W-1:0] f_re(input logic [W-1:0] re, input logic [W-1:0] im);
    if (re == V1_RE && im == V1_IM) return R1_RE;
    if (re == V2_RE && im == V2_IM) return R2_RE;
    return re ^ (im << 1);
  endfunction

  function automatic logic [W-1:0] f_im(input logic [W-1:0] re, input logic [W-1:0] im);
    if (re == V1_RE && im == V1_IM) return R1_IM;
    if (re == V2_RE && im == V2_IM) return R2_IM;
    return re + im + W'(1);
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      pr[0][l] <= f_re(sq_a[l], sq_b[l]);
      pi[0][l] <= f_im(sq_a[l], sq_b[l]);
    end
    for (int k = 1; k < LAT; k++) begin
      pr[k] <= pr[k-1];
      pi[k] <= pi[k-1];
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
    int waitc;
    waitc = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    while (!in_ready && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for element re=%h", re);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic poll_issue(input string name, input logic [W-1:0] a1, input logic [W-1:0] a2);
    int c;
    c = 0;
    while (!(sq_a[0] == a1 && sq_a[1] == a2) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk(name, W'(sq_a[0] == a1 && sq_a[1] == a2), W'(1));
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk(name, W'(exp_q.size()), W'(0));
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got re=%h im=%h last=%0d", out_re, out_im, out_last);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          if (out_re !== e.ere || out_im !== e.eim || out_last !== e.elast) begin
            errors++;
            $display("FAIL out_elem: got re=%h im=%h last=%0d expected re=%h im=%h last=%0d",
                     out_re, out_im, out_last, e.ere, e.eim, e.elast);
          end
        end
      end
    end
  endtask

  task automatic issue_loop();
    logic [W-1:0] prev;
    prev = sq_a[0];
    forever begin
      @(negedge clk);
      if (sq_a[0] != prev) issue_cnt++;
      prev = sq_a[0];
    end
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] re, input logic [W-1:0] im,
                         input logic last, input logic elast);
    tbl[i].re    = re;
    tbl[i].im    = im;
    tbl[i].last  = last;
    tbl[i].ere   = f_re(re, im);
    tbl[i].eim   = f_im(re, im);
    tbl[i].elast = elast;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nout0, lat;
    checks = 0; errors = 0; n_out = 0; issue_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0; out_ready = 1'b0;

    set_vec(0, V1_RE, V1_IM, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) set_vec(i, (i % 2 == 1) ? V1_RE : V2_RE, (i % 2 == 1) ? V1_IM : V2_IM, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) set_vec(5 + i, W'(i + 1), W'(1000 + i), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) set_vec(21 + k, W'(256 + k), W'(512 + k), 1'b1, 1'b1);
    for (int i = 25; i <= 28; i++) set_vec(i, V2_RE, V2_IM, (i == 28), (i == 28));
    tbl[0].ere = R1_RE;  tbl[0].eim = R1_IM;
    tbl[1].ere = R1_RE;  tbl[1].eim = R1_IM;
    tbl[2].ere = R2_RE;  tbl[2].eim = R2_IM;
    tbl[3].ere = R1_RE;  tbl[3].eim = R1_IM;
    tbl[4].ere = R2_RE;  tbl[4].eim = R2_IM;

    fork
      mon_loop();
      issue_loop();
    join_none

    // Reset state
    idle(3);
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_re", out_re, W'(0));
    chk("rst_out_last", W'(out_last), W'(0));
    chk("rst_sq_A1", sq_a[0], W'(0));
    chk("rst_sq_B4", sq_b[3], W'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    out_ready = 1'b1;

    // Single-element group
    nout0 = n_out;
    exp_q.push_back(tbl[0]);
    send(tbl[0].re, tbl[0].im, tbl[0].last);
    poll_issue("single_issue", V1_RE, W'(0));
    chk("single_B1", sq_b[0], V1_IM);
    for (int l = 1; l < 4; l++) begin
      chk("single_zero_A", sq_a[l], W'(0));
      chk("single_zero_B", sq_b[l], W'(0));
    end
    drain("single_drain");
    idle(10);
    chk("single_count", W'(n_out - nout0), W'(1));

    // Full group with first-output latency
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(tbl[i]);
      send(tbl[i].re, tbl[i].im, tbl[i].last);
    end
    poll_issue("full_issue", V1_RE, V2_RE);
    chk("full_A3", sq_a[2], V1_RE);
    chk("full_A4", sq_a[3], V2_RE);
    chk("full_B2", sq_b[1], V2_IM);
    chk("full_B3", sq_b[2], V1_IM);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("full_latency", W'(lat), W'(LAT + 1));
    drain("full_drain");

    // Backpressure: only FD groups may issue while the consumer stalls
    out_ready = 1'b0;
    issue_cnt = 0;
    fork
      begin
        for (int i = 5; i < 21; i++) begin
          exp_q.push_back(tbl[i]);
          send(tbl[i].re, tbl[i].im, tbl[i].last);
        end
      end
      begin
        idle(60);
        chk("bp_issue_cnt", W'(issue_cnt), W'(FD));
        chk("bp_in_ready", W'(in_ready), W'(0));
        chk("bp_out_valid", W'(out_valid), W'(1));
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Final-lane pop in the same cycle as an issue at credit FD-1
    out_ready = 1'b0;
    issue_cnt = 0;
    exp_q.push_back(tbl[21]);
    send(tbl[21].re, tbl[21].im, tbl[21].last);
    idle(15);
    chk("sim_head_valid", W'(out_valid), W'(1));
    exp_q.push_back(tbl[22]);
    send(tbl[22].re, tbl[22].im, tbl[22].last);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 23; i <= 24; i++) begin
      exp_q.push_back(tbl[i]);
      send(tbl[i].re, tbl[i].im, tbl[i].last);
    end
    idle(20);
    chk("sim_issue_cnt", W'(issue_cnt), W'(3));
    chk("sim_in_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    drain("sim_drain");

    // Reset two cycles after an issue discards that group
    nout0 = n_out;
    send(V1_RE, V1_IM, 1'b1);
    poll_issue("mid_issue", V1_RE, W'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", W'(in_ready), W'(0));
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_post_in_ready", W'(in_ready), W'(1));
    chk("mid_post_sq_A1", sq_a[0], W'(0));
    idle(15);
    chk("mid_no_output", W'(n_out - nout0), W'(0));
    for (int i = 25; i <= 28; i++) begin
      exp_q.push_back(tbl[i]);
      send(tbl[i].re, tbl[i].im, tbl[i].last);
    end
    drain("mid_drain");
    idle(10);
    chk("mid_count", W'(n_out - nout0), W'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp2_sq_stream_ctrl.md
Name: fp2_sq_stream_ctrl

Overview:
- Stream front-end and back-end for the 4-lane pipelined Fp2 squaring unit fp2_ptwise_sq.
- Packs a valid/ready stream of Fp2 elements (re, im) into 4-lane groups and drives the unit's A1..A4 (re) and B1..B4 (im) inputs.
- Tracks each group through the fixed pipeline latency, captures D*_re/D*_im, buffers them and replays them as an in-order output stream with backpressure.
- Needed because the squaring unit has no stall input; this block guarantees results are never dropped.

Parameters:
- LATENCY, 6, cycles from a group on sq_A*/sq_B* to its result on sq_D*; must equal the unit's LATENCY_FP2_PTWISE_SQUARE.
- FIFO_DEPTH, 4, result buffer depth in groups (power of two, >=2).
- W, 255, Fp2 coordinate width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts element
- in_re  in  W  element real part
- in_im  in  W  element imaginary part
- in_last  in  1  element closes current group (flush partial)
- sq_A1..sq_A4  out  W each  lane real parts to unit
- sq_B1..sq_B4  out  W each  lane imaginary parts to unit
- sq_D1_re..sq_D4_re  in  W each  lane squared real parts from unit
- sq_D1_im..sq_D4_im  in  W each  lane squared imaginary parts from unit
- out_valid  out  1  result element valid
- out_ready  in  1  consumer accepts result
- out_re  out  W  result real part = re^2 - im^2 mod p
- out_im  out  W  result imaginary part = 2*re*im mod p
- out_last  out  1  last element of a group closed by in_last

Behaviour:
- Reset: in_ready=0 during reset, 1 the first cycle after if credit allows. out_valid=0, out_last=0, out_re/out_im=0, all sq_A*/sq_B*=0. Packer count, pipeline tracker, FIFO and credit counter are cleared.
- Reset mid-operation discards everything in flight. Results emerging from the unit after reset are ignored because the tracker bits are 0.
- Packer: 4 slots, count cnt 0..4, closed flag.
  - Accept when in_valid && in_ready. The element goes into slot cnt, and cnt increments.
  - The closed flag is set if in_last is accepted or cnt becomes 4.
  - in_ready = !closed.
  - No accept in the same cycle as issue, so there is one bubble per group.
- Issue: occurs in the cycle when closed && credit < FIFO_DEPTH.
  - At that edge, sq_A*/sq_B* registers load the slots. Lanes >= cnt load 0.
  - Tracker entry {valid=1, n=cnt, last=in_last-flag} enters the LATENCY-stage shift register.
  - The packer clears and credit increments.
- sq_A*/sq_B* hold their value until the next issue. The unit sees a repeated group harmlessly; only tracker-valid results are captured.
- Capture: a group driven on sq_* in cycle t has its results on sq_D* in cycle t+LATENCY. When the tracker stage LATENCY is valid, all 4 lanes plus n and last are written to the FIFO at the end of that cycle.
- Overflow is impossible: credit counts groups issued and not fully drained, and issue requires credit < FIFO_DEPTH.
- Output: the head group is serialised lanes 0..n-1, one element per out_valid && out_ready.
  - out_last=1 only on lane n-1 of a group with last=1.
  - After lane n-1 pops, the FIFO advances and credit decrements.
  - If a pop and an issue happen in the same cycle, credit is unchanged.
  - out_valid=1 whenever the FIFO is non-empty. Outputs are combinational from the head entry and lane pointer.
- Ordering: output order equals input order, with no gaps or duplication.
- Zero-length groups do not exist: in_last with cnt=0 still stores that element, so n>=1.

Test Plan:
- Test vectors:
  - V1: re=3807ed85e85d8b3fbd5a293a18bb42f0912b8e383d833a9a269d132d5a5167b, im=127ba0471a1f3d76c58bca5bc731dd6f91ae57c60ea264fecde8b73482c3495.
  - V2: re=34e0b04174d94060cacc82cd69eee90e724fe81f8a43b14ccd8904ef5a965f9, im=37574a8b477caf2a5f274ab5c718332ee00fefa49e0c5518b2de38c133d33ea.
- Single-element group: V1 with in_last=1, real fp2_ptwise_sq attached, out_ready=1.
  - Lanes 2-4 of sq_A*/sq_B* are 0 at issue.
  - Exactly one output with out_re=3c1c4f9467e51a19be97071693ad823e905a8da3ecaa181fff9bbaf6a923321, out_im=37319e18249d047e4001270f26108a057741e2280414936d5dd56bb2ac5796a, out_last=1.
- Full group: V1, V2, V1, V2, in_last=0, out_ready=1.
  - One issue carries lanes in order.
  - Outputs alternate V1 result and V2 result (re=6961fa8023ef02728923172070710add14eb25535c8e17139bbb3d0ad46ef9, im=7a46fd2123e88c6240961494f8e20906e062222d240620f13f0044ec411a7c8), with out_last=0 throughout.
  - The first out_valid appears exactly LATENCY+1 cycles after the issue cycle.
- Backpressure: FIFO_DEPTH=2, out_ready=0, stream 16 elements.
  - Exactly 2 groups issue and the third group stalls closed with in_ready=0.
  - After out_ready=1, all 16 results arrive in order with none lost.
- Simultaneous pop/issue: credit=FIFO_DEPTH-1 with a pop of the final lane in the same cycle as an issue.
  - Credit stays unchanged and the FIFO pointers stay consistent.
- Reset mid-flight: assert rst 2 cycles after an issue.
  - No out_valid for that group afterwards.
  - The next fresh V2 group yields only V2 results.
